// File: rtl/icb_pkg.sv
// Shared ICB definitions: address-region heads, bus widths and the response beat.
package icb_pkg;

  localparam int ICB_ADW = 32;
  localparam int ICB_DW  = 64;
  localparam int ICB_MW  = ICB_DW / 8;

  localparam logic [3:0] BIU_OUTSIDE_HEAD = 4'b1111;
  localparam logic [3:0] INT_ADDR_HEAD    = 4'b0000;
  localparam logic [3:0] ITCM_ADDR_HEAD   = 4'b1000;
  localparam logic [3:0] DTCM_ADDR_HEAD   = 4'b0011;

  typedef struct packed {
    logic [ICB_DW-1:0] rdata;
    logic              err;
  } icb_rsp_t;

endpackage

// File: rtl/icb_rsp_fifo.sv
// Two-entry response FIFO; push data visible at head the cycle after push, no bypass.
// Never refuses a push: the caller bounds occupancy, and overflow is flagged as an assertion.
module icb_rsp_fifo
  import icb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  icb_rsp_t   push_dat,
  input  logic       pop,
  output icb_rsp_t   head,
  output logic       full,
  output logic       empty,
  output logic [1:0] cnt
);

  icb_rsp_t ent [2];
  logic     wptr;
  logic     rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: only entries below cnt are ever observed.
  always_ff @(posedge clk) begin
    if (push) ent[wptr] <= push_dat;
  end

  assign head  = ent[rptr];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/icb_dtcm_slv.sv
// DTCM ICB responder: 1-cycle read latency, 1 cmd/cycle, 2-deep rsp buffering stalls cmd when full.
// Optional address checking via `define ICB_DTCM_ERR_CHK_EN.
module icb_dtcm_slv
  import icb_pkg::*;
#(
  parameter int ADW   = 32,
  parameter int DW    = 64,
  parameter int DEPTH = 4096
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           icb_cmd_valid,
  output logic           icb_cmd_ready,
  input  logic [ADW-1:0] icb_cmd_addr,
  input  logic           icb_cmd_read,
  input  logic [DW-1:0]  icb_cmd_wdata,
  input  logic [7:0]     icb_cmd_wmask,
  output logic           icb_rsp_valid,
  input  logic           icb_rsp_ready,
  output logic [DW-1:0]  icb_rsp_rdata,
  output logic           icb_rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = DW / 8;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;
  logic [AW-1:0] widx;
  logic          cmd_hs;
  logic          cmd_err;
  logic          s1_vld;
  logic          s1_read;
  logic          s1_err;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [1:0]    fifo_cnt;
  icb_rsp_t      s1_rsp;
  icb_rsp_t      fifo_head;
  icb_rsp_t      rsp;

  assign widx = icb_cmd_addr[3 +: AW];

`ifdef ICB_DTCM_ERR_CHK_EN
  assign cmd_err = (icb_cmd_addr[ADW-1 -: 4] != DTCM_ADDR_HEAD)
                 | (|icb_cmd_addr[2:0])
                 | (|icb_cmd_addr[ADW-5:3+AW]);
`else
  logic unused_addr;
  assign unused_addr = ^{icb_cmd_addr[ADW-1:3+AW], icb_cmd_addr[2:0]};
  assign cmd_err     = 1'b0;
`endif

  // Outstanding count comes from registers only, so ready has no path from valid or rsp_ready.
  assign icb_cmd_ready = (({1'b0, s1_vld} + fifo_cnt) < 2'd2);
  assign cmd_hs        = icb_cmd_valid & icb_cmd_ready;

  always_ff @(posedge clk) begin
    if (cmd_hs && !icb_cmd_read && !cmd_err) begin
      for (int i = 0; i < NB; i++) begin
        if (icb_cmd_wmask[i]) mem[widx][i*8 +: 8] <= icb_cmd_wdata[i*8 +: 8];
      end
    end
    if (cmd_hs && icb_cmd_read && !cmd_err) rd_q <= mem[widx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_read <= 1'b0;
      s1_err  <= 1'b0;
    end else begin
      s1_vld  <= cmd_hs;
      s1_read <= cmd_hs & icb_cmd_read;
      s1_err  <= cmd_hs & cmd_err;
    end
  end

  assign s1_rsp.rdata = (s1_read && !s1_err) ? rd_q : '0;
  assign s1_rsp.err   = s1_err;

  // s1 is consumed directly only when nothing older is queued ahead of it.
  assign pop  = ~fifo_empty & icb_rsp_ready;
  assign push = s1_vld & ~(fifo_empty & icb_rsp_ready);

  icb_rsp_fifo u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (s1_rsp),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .cnt      (fifo_cnt)
  );

  assign rsp           = fifo_empty ? s1_rsp : fifo_head;
  assign icb_rsp_valid = ~fifo_empty | s1_vld;
  assign icb_rsp_rdata = rsp.rdata;
  assign icb_rsp_err   = rsp.err;

endmodule

// File: tb/tb_icb_dtcm_slv.sv
// Randomised bench for icb_dtcm_slv with an in-order expected-response queue and word-level memory model.
module tb_icb_dtcm_slv;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_read = 1'b0;
  logic [63:0] cmd_wdata = '0;
  logic [7:0]  cmd_wmask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  icb_dtcm_slv #(.ADW(32), .DW(64), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .icb_cmd_valid (cmd_valid),
    .icb_cmd_ready (cmd_ready),
    .icb_cmd_addr  (cmd_addr),
    .icb_cmd_read  (cmd_read),
    .icb_cmd_wdata (cmd_wdata),
    .icb_cmd_wmask (cmd_wmask),
    .icb_rsp_valid (rsp_valid),
    .icb_rsp_ready (rsp_ready),
    .icb_rsp_rdata (rsp_rdata),
    .icb_rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    bit          chk;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mdl [int];
  int          tests = 0;
  int          fails = 0;
  int          rsp_fires = 0;
  int          rdy_low = 0;
  int          cyc = 0;
  bit          armed = 0;
  bit          rand_rdy = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] a);
`ifdef ICB_DTCM_ERR_CHK_EN
    return (a[31:28] != 4'h3) || (a[2:0] != 3'd0) || (((a & 32'h0FFF_FFFF) >> 3) >= DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_accept(input logic rd, input logic [31:0] a,
                                       input logic [63:0] wd, input logic [7:0] wm);
    exp_t e;
    int   idx = int'((a >> 3) % DEPTH);
    bit   er  = addr_err(a);
    e.err = er;
    e.rdata = '0;
    e.chk = 1;
    if (rd && !er) begin
      if (mdl.exists(idx)) e.rdata = mdl[idx];
      else e.chk = 0;
    end else if (!rd && !er) begin
      if (mdl.exists(idx) || wm == 8'hFF) begin
        logic [63:0] w = mdl.exists(idx) ? mdl[idx] : 64'h0;
        for (int b = 0; b < 8; b++) if (wm[b]) w[b*8 +: 8] = wd[b*8 +: 8];
        mdl[idx] = w;
      end
    end
    q.push_back(e);
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Outstanding responses = queue depth; the DUT must expose exactly that.
  always @(negedge clk) begin
    if (armed) begin
      chk("cmd_ready", 64'(cmd_ready), 64'(q.size() < 2));
      chk("rsp_valid", 64'(rsp_valid), 64'(q.size() > 0));
      if (q.size() > 0 && rsp_valid) begin
        chk("rsp_err", 64'(rsp_err), 64'(q[0].err));
        if (q[0].chk) chk("rsp_rdata", rsp_rdata, q[0].rdata);
      end
      if (!cmd_ready) rdy_low++;
    end
    if (rst) q.delete();
    else begin
      if (rsp_valid && rsp_ready && q.size() > 0) begin
        void'(q.pop_front());
        rsp_fires++;
      end
      if (cmd_valid && cmd_ready) model_accept(cmd_read, cmd_addr, cmd_wdata, cmd_wmask);
    end
  end

  task automatic issue(input logic rd, input logic [31:0] a, input logic [63:0] wd, input logic [7:0] wm);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_wmask = wm;
    @(negedge clk);
    while (!cmd_ready) begin
      n++;
      if (n > 50) begin
        chk("cmd_accept_timeout", 64'(n), 64'(0));
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] held;
    int          r0;
    int          c0;
    int          l0;

    @(posedge clk);
    #1;
    armed = 1;
    @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_rdata", rsp_rdata, 64'(0));
    chk("reset_rsp_err", 64'(rsp_err), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) issue(1'b0, 32'h3000_0000 + 32'(i * 8), {$urandom, $urandom}, 8'hFF);
    drain();

    issue(1'b0, 32'h3000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF);
    issue(1'b1, 32'h3000_0010, 64'h0, 8'h00);
    @(negedge clk);
    chk("rd_full_valid_t1", 64'(rsp_valid), 64'(1));
    chk("rd_full_data", rsp_rdata, 64'h0123_4567_89AB_CDEF);
    chk("rd_full_err", 64'(rsp_err), 64'(0));
    @(posedge clk);
    #1;

    issue(1'b0, 32'h3000_0010, {8{8'hA5}}, 8'h04);
    issue(1'b1, 32'h3000_0010, 64'h0, 8'hFF);
    @(negedge clk);
    chk("rd_byte_data", rsp_rdata, 64'h0123_4567_89A5_CDEF);
    @(posedge clk);
    #1;

    issue(1'b0, 32'h3000_0018, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    @(negedge clk);
    chk("wr_nomask_err", 64'(rsp_err), 64'(0));
    @(posedge clk);
    #1;
    drain();

    r0 = rsp_fires;
    c0 = cyc;
    l0 = rdy_low;
    for (int i = 0; i < 8; i++) issue(1'b1, 32'h3000_0000 + 32'(i * 8), 64'h0, 8'h00);
    chk("b2b_cycles", 64'(cyc - c0), 64'(8));
    @(negedge clk);
    @(negedge clk);
    chk("b2b_rsp_count", 64'(rsp_fires - r0), 64'(8));
    chk("b2b_ready_low", 64'(rdy_low - l0), 64'(0));
    @(posedge clk);
    #1;

    rsp_ready = 1'b0;
    issue(1'b1, 32'h3000_0010, 64'h0, 8'h00);
    issue(1'b1, 32'h3000_0000, 64'h0, 8'h00);
    cmd_valid = 1'b1;
    cmd_read  = 1'b1;
    cmd_addr  = 32'h3000_0008;
    @(negedge clk);
    chk("bp_ready_low", 64'(cmd_ready), 64'(0));
    held = rsp_rdata;
    chk("bp_head_data", held, 64'h0123_4567_89A5_CDEF);
    repeat (3) @(negedge clk);
    chk("bp_hold_stable", rsp_rdata, held);
    chk("bp_hold_valid", 64'(rsp_valid), 64'(1));
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    issue(1'b1, 32'h3000_0008, 64'h0, 8'h00);
    drain();

`ifdef ICB_DTCM_ERR_CHK_EN
    issue(1'b1, 32'h2000_0000, 64'h0, 8'h00);
    @(negedge clk);
    chk("err_head_flag", 64'(rsp_err), 64'(1));
    chk("err_head_rdata", rsp_rdata, 64'h0);
    @(posedge clk);
    #1;
    issue(1'b0, 32'h3000_0000, 64'h1111_2222_3333_4444, 8'hFF);
    issue(1'b0, 32'h3000_0004, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    @(negedge clk);
    chk("err_align_flag", 64'(rsp_err), 64'(1));
    @(posedge clk);
    #1;
    issue(1'b1, 32'h3000_0000, 64'h0, 8'h00);
    @(negedge clk);
    chk("err_mem_unchanged", rsp_rdata, 64'h1111_2222_3333_4444);
    @(posedge clk);
    #1;
    drain();
`endif

    issue(1'b0, 32'h3000_0020, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
    drain();
    rsp_ready = 1'b0;
    issue(1'b1, 32'h3000_0000, 64'h0, 8'h00);
    issue(1'b1, 32'h3000_0008, 64'h0, 8'h00);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 64'(rsp_valid), 64'(0));
    chk("rst_mid_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    issue(1'b1, 32'h3000_0020, 64'h0, 8'h00);
    @(negedge clk);
    chk("rst_persist_data", rsp_rdata, 64'hDEAD_BEEF_0BAD_F00D);
    @(posedge clk);
    #1;
    drain();

    rand_rdy = 1;
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a;
      int          r;
      a = 32'h3000_0000 + 32'($urandom_range(0, 15) * 8);
      r = $urandom_range(0, 19);
      if (r == 0) a[31:28] = 4'h2;
      if (r == 1) a[2:0] = 3'($urandom_range(1, 7));
      if (r == 2) a[15] = 1'b1;
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom));
    end
    rand_rdy = 0;
    @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
